// File: rtl/lif_membrane.sv
// ---------------------------------------------------------------------------
// lif_membrane
//   Leaky integrate-and-fire membrane stage. On every valid time step the
//   stored membrane potential is leaked by a right shift. The unsigned
//   synaptic sum is then added with saturation, and the result is compared
//   against a programmable threshold. A crossing emits a one-cycle spike,
//   clears the membrane and starts a refractory countdown. During the
//   countdown all input is dropped.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   sum_in        in   [SUM_WIDTH-1:0] unsigned synaptic sum
//   sum_valid     in   strobe: sum_in is a new time step
//   threshold     in   [MEM_WIDTH-1:0] unsigned firing threshold
//   leak_shift    in   [2:0] leak = membrane >> leak_shift
//   refrac_cycles in   [REF_WIDTH-1:0] refractory length after a spike
//   spike         out  registered one-cycle firing pulse
//   membrane      out  [MEM_WIDTH-1:0] registered membrane potential
//   refractory    out  high while the refractory counter is nonzero
//
// Handshake: sum_valid is a pure strobe with no ready/back-pressure. A step
// is accepted on a rising edge where sum_valid=1 and the neuron is not
// refractory. Otherwise the step is silently dropped.
// ---------------------------------------------------------------------------
module lif_membrane #(
    parameter int SUM_WIDTH = 7,
    parameter int MEM_WIDTH = 10,
    parameter int REF_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SUM_WIDTH-1:0] sum_in,
    input  logic                 sum_valid,
    input  logic [MEM_WIDTH-1:0] threshold,
    input  logic [2:0]           leak_shift,
    input  logic [REF_WIDTH-1:0] refrac_cycles,
    output logic                 spike,
    output logic [MEM_WIDTH-1:0] membrane,
    output logic                 refractory
);

    // The refractory counter is the only state register. The enum below is
    // a decoded view of it, which keeps the next-state logic readable.
    typedef enum logic {
        ST_INTEGRATE = 1'b0,
        ST_REFRACT   = 1'b1
    } state_t;

    state_t               state;
    logic [REF_WIDTH-1:0] ref_cnt;
    logic [REF_WIDTH-1:0] ref_cnt_next;
    logic [MEM_WIDTH-1:0] mem_q;
    logic [MEM_WIDTH-1:0] mem_next;
    logic                 spike_q;
    logic                 spike_next;

    logic [MEM_WIDTH-1:0] leak_amt;
    logic [MEM_WIDTH-1:0] u_leak;
    logic [MEM_WIDTH:0]   u_sum;
    logic [MEM_WIDTH-1:0] u_sat;
    logic                 fire;

    assign state = (|ref_cnt) ? ST_REFRACT : ST_INTEGRATE;

    // leak_shift=0 subtracts the whole value, so u_leak is 0 with no
    // special case.
    assign leak_amt = mem_q >> leak_shift;
    assign u_leak   = mem_q - leak_amt;

    // Add one bit of headroom, then clamp to all-ones on carry-out.
    assign u_sum = {1'b0, u_leak} + {{(MEM_WIDTH + 1 - SUM_WIDTH){1'b0}}, sum_in};
    assign u_sat = u_sum[MEM_WIDTH] ? {MEM_WIDTH{1'b1}} : u_sum[MEM_WIDTH-1:0];
    assign fire  = (u_sat >= threshold);

    always_comb begin
        mem_next     = mem_q;
        spike_next   = 1'b0;
        ref_cnt_next = ref_cnt;
        case (state)
            ST_INTEGRATE: begin
                if (sum_valid) begin
                    if (fire) begin
                        mem_next     = '0;
                        spike_next   = 1'b1;
                        // With refrac_cycles=0 this leaves us in INTEGRATE,
                        // so a spike is possible on the very next step.
                        ref_cnt_next = refrac_cycles;
                    end else begin
                        mem_next = u_sat;
                    end
                end
            end
            ST_REFRACT: begin
                mem_next     = '0;
                ref_cnt_next = ref_cnt - REF_WIDTH'(1);
            end
            default: begin
                mem_next     = '0;
                ref_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q   <= '0;
            spike_q <= 1'b0;
            ref_cnt <= '0;
        end else begin
            mem_q   <= mem_next;
            spike_q <= spike_next;
            ref_cnt <= ref_cnt_next;
        end
    end

    assign spike      = spike_q;
    assign membrane   = mem_q;
    assign refractory = (state == ST_REFRACT);

endmodule
